pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder for the RiscV datapath: WIDTH-bit A+B+cin split into
//  STAGES chunks, one chunk per cycle, so long adds meet timing. Valid/ready handshake on both sides,
//  throughput 1 op/cycle, latency STAGES. Produces sum, carry-out, signed overflow and zero flag for the ALU.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//  STAGES  4   pipeline depth = chunks; CHUNK = WIDTH/STAGES bits added per stage; STAGES>=1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      block can accept bundle this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  sub        in   1      subtract mode (only with PIPE_ADDER_SUB_EN; tie 0 otherwise)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (sign(a)==sign(b') && sign(sum)!=sign(a))
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset: all stage valid bits, out_valid, sum, cout, ovf, zero = 0; in_ready = 1 in the cycle after reset.
//  - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational). Transfer on in_valid&&in_ready.
//  - Stage k (0..STAGES-1) on adv: adds chunk k of a,b with carry from stage k-1 (stage 0 uses cin), registers
//    partial sum low (k+1)*CHUNK bits, carry, unconsumed upper operand bits, sign bits of a/b', valid.
//  - Each chunk add is full-adder ripple: s_i = a_i^b_i^c_i, c_{i+1} = (a_i^b_i)&c_i | a_i&b_i.
//  - Latency: accepted at edge N -> out_valid at edge N+STAGES when never stalled; 1 result/cycle sustained.
//  - Stall: !adv freezes every stage register and outputs; held result stable until out_ready.
//  - Bubbles are not collapsed: an invalid slot advances like a valid one.
//  - Arithmetic mod 2^WIDTH; cout/ovf/zero valid only while out_valid, registered with sum.
//  - in_valid=0 with in_ready=1: stage-0 valid loads 0. Operand values ignored when in_valid=0.
//  - Reset mid-operation: all in-flight ops dropped, no partial result emitted.
//  - STAGES=1: single registered add, latency 1.
// CONFIGURATION
//  - PIPE_ADDER_SUB_EN defined: sub port honoured; b' = sub ? ~b : b, effective carry-in = cin ^ sub
//    (sub=1,cin=0 gives a-b; cout=1 means no borrow). ovf uses b'.
//  - Undefined: sub port present but ignored; b' = b, carry-in = cin.
// STRUCTURE
//  - Shared package/include riscv_alu_pkg: localparams for default WIDTH=32, STAGES=4, flag bit order
//    {ovf,cout,zero} as typedef/`define alu_flags_t.
//  - One sub-module: adder_chunk #(CHUNK) — combinational CHUNK-bit ripple (a,b,cin -> s,cout);
//    instantiated STAGES times in a generate loop; pipeline regs live in the top module.
// TESTING
//  - Basic: a=32'h0000_0001,b=32'h0000_0002,cin=0 -> 4 cycles later sum=3,cout=0,ovf=0,zero=0.
//  - Carry chain across all chunks: a=32'hFFFF_FFFF,b=0,cin=1 -> sum=0,cout=1,zero=1,ovf=0.
//  - Signed overflow: a=32'h7FFF_FFFF,b=1 -> sum=32'h8000_0000,ovf=1,cout=0.
//  - Back-to-back + stall: 8 ops one per cycle, out_ready low cycles 6-8 -> all 8 results in order, none lost
//    or duplicated, in_ready low while out_valid&&!out_ready.
//  - Reset mid-flight: 3 ops accepted, rst pulsed 1 cycle -> out_valid stays 0, no stale results after.
//  - SUB_EN build: sub=1,a=5,b=7,cin=0 -> sum=32'hFFFF_FFFE,cout=0; a=7,b=5 -> sum=2,cout=1.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared ALU definitions: default adder geometry and the packed result-flag layout {ovf, cout, zero}.
package riscv_alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_STAGES = 4;

    typedef struct packed {
        logic ovf;
        logic cout;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit full-adder ripple: (a, b, cin) -> (s, cout).
// Latency 0; no flow control, the enclosing pipeline stage owns the handshake.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = ((a[i] ^ b[i]) & c[i]) | (a[i] & b[i]);
        end
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, WIDTH bits in STAGES chunks; sum/cout/ovf/zero; `PIPE_ADDER_SUB_EN enables sub.
// Latency STAGES cycles, throughput 1 op/cycle.
// Backpressure: whole pipe advances only when the output slot is empty or consumed (in_ready = adv).
module pipelined_adder
    import riscv_alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = ALU_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, STAGES >= 1");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = cin;
`endif

    // Stage k consumes the low chunk of the operand bits still pending and forwards only
    // the unconsumed upper bits, so registers shrink as the partial sum grows.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int REM_IN = WIDTH - k * CHUNK;
        localparam int DONE   = (k + 1) * CHUNK;

        logic [REM_IN-1:0] a_in;
        logic [REM_IN-1:0] b_in;
        logic              c_in;
        logic              v_in;
        logic [CHUNK-1:0]  s;
        logic              co;
        logic [DONE-1:0]   ps_next;
        logic [DONE-1:0]   ps_q;
        logic              v_q;

        if (k == 0) begin : g_first
            assign a_in    = a;
            assign b_in    = b_eff;
            assign c_in    = cin_eff;
            assign v_in    = in_valid;
            assign ps_next = s;
        end else begin : g_mid
            assign a_in    = stg[k-1].g_fwd.a_q;
            assign b_in    = stg[k-1].g_fwd.b_q;
            assign c_in    = stg[k-1].g_fwd.c_q;
            assign v_in    = stg[k-1].v_q;
            assign ps_next = {s, stg[k-1].ps_q};
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_in[CHUNK-1:0]),
            .b    (b_in[CHUNK-1:0]),
            .cin  (c_in),
            .s    (s),
            .cout (co)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                ps_q <= '0;
                v_q  <= 1'b0;
            end else if (adv) begin
                ps_q <= ps_next;
                v_q  <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM_IN-CHUNK-1:0] a_q;
            logic [REM_IN-CHUNK-1:0] b_q;
            logic                    c_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_in[REM_IN-1:CHUNK];
                    b_q <= b_in[REM_IN-1:CHUNK];
                    c_q <= co;
                end
            end
        end else begin : g_last
            alu_flags_t flags_d;
            alu_flags_t flags_q;

            // The sign bits of a and b' are the MSBs of the final chunk's operands.
            always_comb begin
                flags_d      = '0;
                flags_d.ovf  = (a_in[REM_IN-1] == b_in[REM_IN-1]) && (s[CHUNK-1] != a_in[REM_IN-1]);
                flags_d.cout = co;
                flags_d.zero = (ps_next == '0);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    flags_q <= '0;
                end else if (adv) begin
                    flags_q <= flags_d;
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].ps_q;
    assign cout      = stg[STAGES-1].g_last.flags_q.cout;
    assign ovf       = stg[STAGES-1].g_last.flags_q.ovf;
    assign zero      = stg[STAGES-1].g_last.flags_q.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: vector table, scoreboard queue, stall/reset sequences.
module tb_pipelined_adder;
    import riscv_alu_pkg::*;

    localparam int W = 32;
    localparam int S = 4;
`ifdef PIPE_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    res_t         sb[$];
    vec_t         tbl[8];
    int           checks = 0;
    int           errors = 0;
    int           npop = 0;
    bit           acc = 1'b0;
    bit           prev_stall = 1'b0;
    bit           use_model = 1'b1;
    logic [W-1:0] prev_sum = '0;
    res_t         exp_next = '0;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb_);
        logic [W-1:0] yp;
        logic         ce;
        logic [W:0]   r;
        res_t         m;
        yp     = (SUB_EN && sb_) ? ~y : y;
        ce     = ci ^ (SUB_EN && sb_);
        r      = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, ce};
        m.sum  = r[W-1:0];
        m.cout = r[W];
        m.ovf  = (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]);
        m.zero = (r[W-1:0] == '0);
        return m;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                input logic [W-1:0] s_, input logic co_, input logic ov_,
                                input logic z_);
        vec_t v;
        v.a   = x;
        v.b   = y;
        v.cin = ci;
        v.exp = '{sum: s_, cout: co_, ovf: ov_, zero: z_};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are set at the falling edge; everything is sampled 1 time unit later.
    task automatic cycle();
        res_t e;
        #1;
        acc = 1'b0;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_sum", {32'd0, sum}, {32'd0, prev_sum});
            end
            if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            if (out_valid && out_ready) begin
                npop++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=unexpected result %h expected=no output", sum);
                end else begin
                    e = sb.pop_front();
                    chk("result", {29'd0, sum, cout, ovf, zero}, {29'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(use_model ? model(a, b, cin, sub) : exp_next);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) cycle();
        repeat (S + 2) cycle();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int           lat;
        int           sent;
        int           pop0;
        logic [W-1:0] ops_a[8];
        logic [W-1:0] ops_b[8];

        tbl[0] = mk(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tbl[2] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        tbl[3] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        tbl[4] = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        tbl[5] = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Reset with junk on the inputs
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'hDEAD_BEEF;
        b         = 32'h1234_5678;
        cin       = 1'b1;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // Latency: presented in one cycle, result visible STAGES cycles later
        use_model = 1'b0;
        exp_next  = '{sum: 32'd3, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        in_valid  = 1'b1;
        a         = 32'd1;
        b         = 32'd2;
        cin       = 1'b0;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        chk("latency", 64'(lat), 64'(S));
        drain();

        // Table vectors back to back
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a        = tbl[i].a;
            b        = tbl[i].b;
            cin      = tbl[i].cin;
            exp_next = tbl[i].exp;
            cycle();
            chk("tbl_accept", {63'd0, acc}, 64'd1);
        end
        drain();

        // 8 ops one per cycle with out_ready low in cycles 6..8
        use_model = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ops_a[i] = $urandom;
            ops_b[i] = $urandom;
        end
        sent = 0;
        pop0 = npop;
        for (int i = 1; i <= 60 && (npop - pop0) < 8; i++) begin
            out_ready = !(i >= 6 && i <= 8);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a   = ops_a[sent];
                b   = ops_b[sent];
                cin = sent[0];
            end
            cycle();
            if (acc) sent++;
        end
        chk("b2b_count", 64'(npop - pop0), 64'd8);
        drain();

        // Random valid/ready traffic, bubbles included
        acc      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = $urandom;
                b        = $urandom;
                cin      = 1'($urandom_range(0, 1));
                sub      = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
        sub = 1'b0;

        // Reset while three ops are in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            cin      = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rst_flush", {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b1;
        a        = 32'h0000_00FF;
        b        = 32'h0000_0001;
        cin      = 1'b0;
        cycle();
        drain();

`ifdef PIPE_ADDER_SUB_EN
        use_model = 1'b0;
        sub       = 1'b1;
        in_valid  = 1'b1;
        cin       = 1'b0;
        a         = 32'd5;
        b         = 32'd7;
        exp_next  = '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        cycle();
        a         = 32'd7;
        b         = 32'd5;
        exp_next  = '{sum: 32'h0000_0002, cout: 1'b1, ovf: 1'b0, zero: 1'b0};
        cycle();
        a         = 32'h8000_0000;
        b         = 32'd1;
        exp_next  = '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
        cycle();
        sub = 1'b0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
